// File: rtl/cc_aluseq_pkg.sv
// Shared widths, ALU opcodes and sequencer state encoding for the Fibonacci ALU sequencer.
package cc_aluseq_pkg;

    localparam int DATAWIDTH_BUS           = 8;
    localparam int DATAWIDTH_ALU_SELECTION = 4;
    localparam int DATAWIDTH_COUNT         = 5;

    typedef logic [DATAWIDTH_BUS-1:0]           data_t;
    typedef logic [DATAWIDTH_ALU_SELECTION-1:0] alu_sel_t;
    typedef logic [DATAWIDTH_COUNT-1:0]         count_t;

    localparam alu_sel_t ALU_OP_BUSA = 4'b0000;
    localparam alu_sel_t ALU_OP_ADD  = 4'b1000;
    localparam alu_sel_t ALU_OP_INCA = 4'b1010;
    localparam alu_sel_t ALU_OP_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cc_aluseq_counter.sv
// Term index counter: latches N on load, clears the index, increments per term, flags k == N-1.
module cc_aluseq_counter
    import cc_aluseq_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   inc,
    input  count_t terms_in,
    output count_t count,
    output logic   last
);

    count_t count_q, count_d;
    count_t terms_q, terms_d;

    always_comb begin
        terms_d = terms_q;
        count_d = count_q;
        if (load) begin
            terms_d = terms_in;
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + count_t'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            terms_q <= '0;
        end else begin
            count_q <= count_d;
            terms_q <= terms_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == terms_q - count_t'(1));

endmodule

// File: rtl/cc_alu_fibonacci_sequencer.sv
// Drives the shared ALU to stream Fibonacci terms F0..F(N-1), one per clock, with sticky overflow.
// Define CC_ALUSEQ_WRAP_EN to keep running through a carry and emit wrapped terms.
module cc_alu_fibonacci_sequencer
    import cc_aluseq_pkg::*;
(
    input  logic                               CC_ALUSEQ_CLOCK_50,
    input  logic                               CC_ALUSEQ_RESET_InLow,
    input  logic                               CC_ALUSEQ_start_InHigh,
    input  logic [DATAWIDTH_COUNT-1:0]         CC_ALUSEQ_terms_InBUS,
    output logic                               CC_ALUSEQ_busy_OutHigh,
    output logic                               CC_ALUSEQ_done_OutHigh,
    output logic                               CC_ALUSEQ_overflow_OutHigh,
    output logic                               CC_ALUSEQ_valid_OutHigh,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_value_OutBUS,
    output logic [DATAWIDTH_COUNT-1:0]         CC_ALUSEQ_index_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_aluSelection_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataB_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluResult_InBUS,
    input  logic                               CC_ALUSEQ_aluCarry_InLow
);

`ifdef CC_ALUSEQ_WRAP_EN
    localparam bit STOP_ON_CARRY = 1'b0;
`else
    localparam bit STOP_ON_CARRY = 1'b1;
`endif

    state_e state_q, state_d;
    data_t  reg_a_q, reg_a_d;
    data_t  reg_b_q, reg_b_d;
    data_t  value_q, value_d;
    count_t index_q, index_d;
    logic   valid_q, valid_d;
    logic   overflow_q, overflow_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    count_t   k;
    logic     k_last;
    logic     cnt_load, cnt_inc;
    logic     is_add, carry;
    alu_sel_t alu_sel;
    data_t    alu_a, alu_b;

    cc_aluseq_counter u_counter (
        .clk      (CC_ALUSEQ_CLOCK_50),
        .rst_n    (CC_ALUSEQ_RESET_InLow),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .terms_in (CC_ALUSEQ_terms_InBUS),
        .count    (k),
        .last     (k_last)
    );

    // ALU drive is a pure decode of state and index so the result is ready within the same cycle.
    always_comb begin
        alu_sel = ALU_OP_NOP;
        alu_a   = '0;
        alu_b   = '0;
        if (state_q == RUN) begin
            if (k == '0) begin
                alu_sel = ALU_OP_BUSA;
            end else if (k == count_t'(1)) begin
                alu_sel = ALU_OP_INCA;
            end else begin
                alu_sel = ALU_OP_ADD;
                alu_a   = reg_a_q;
                alu_b   = reg_b_q;
            end
        end
    end

    assign is_add = (state_q == RUN) && (k > count_t'(1));
    assign carry  = is_add && !CC_ALUSEQ_aluCarry_InLow;

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        value_d    = value_q;
        index_d    = index_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (CC_ALUSEQ_start_InHigh) begin
                    overflow_d = 1'b0;
                    cnt_load   = 1'b1;
                    state_d    = (CC_ALUSEQ_terms_InBUS == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (carry) overflow_d = 1'b1;
                if (carry && STOP_ON_CARRY) begin
                    state_d = DONE;
                end else begin
                    valid_d = 1'b1;
                    value_d = CC_ALUSEQ_aluResult_InBUS;
                    index_d = k;
                    if (k == '0) begin
                        reg_a_d = '0;
                        reg_b_d = '0;
                    end else if (k == count_t'(1)) begin
                        reg_b_d = CC_ALUSEQ_aluResult_InBUS;
                    end else begin
                        reg_a_d = reg_b_q;
                        reg_b_d = CC_ALUSEQ_aluResult_InBUS;
                    end
                    if (k_last) state_d = DONE;
                    else        cnt_inc = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CC_ALUSEQ_CLOCK_50 or negedge CC_ALUSEQ_RESET_InLow) begin
        if (!CC_ALUSEQ_RESET_InLow) begin
            state_q    <= IDLE;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            value_q    <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            value_q    <= value_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign CC_ALUSEQ_busy_OutHigh        = busy_q;
    assign CC_ALUSEQ_done_OutHigh        = done_q;
    assign CC_ALUSEQ_overflow_OutHigh    = overflow_q;
    assign CC_ALUSEQ_valid_OutHigh       = valid_q;
    assign CC_ALUSEQ_value_OutBUS        = value_q;
    assign CC_ALUSEQ_index_OutBUS        = index_q;
    assign CC_ALUSEQ_aluSelection_OutBUS = alu_sel;
    assign CC_ALUSEQ_aluDataA_OutBUS     = alu_a;
    assign CC_ALUSEQ_aluDataB_OutBUS     = alu_b;

endmodule

// File: tb/tb_cc_alu_fibonacci_sequencer.sv
// Self-checking bench: behavioural ALU, Fibonacci scoreboard, run table plus reset-abort sequence.
module tb_cc_alu_fibonacci_sequencer;
    import cc_aluseq_pkg::*;

`ifdef CC_ALUSEQ_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] value;
        logic [4:0] index;
    } term_t;

    typedef struct {
        int n;
        bit inject;
        int exp_terms;
        bit exp_ovf;
        int exp_last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] terms;
    logic       busy, done, overflow, valid;
    logic [7:0] value;
    logic [4:0] index;
    logic [3:0] alu_sel;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       alu_carry_n;
    logic [8:0] alu_sum;

    term_t sb[$];
    int    n_vec = 0;
    int    n_fail = 0;
    int    term_count = 0;
    int    done_count = 0;
    bit    busy_seen = 1'b0;
    logic [7:0] last_value = '0;
    vec_t  vecs[10];

    cc_alu_fibonacci_sequencer dut (
        .CC_ALUSEQ_CLOCK_50            (clk),
        .CC_ALUSEQ_RESET_InLow         (rst_n),
        .CC_ALUSEQ_start_InHigh        (start),
        .CC_ALUSEQ_terms_InBUS         (terms),
        .CC_ALUSEQ_busy_OutHigh        (busy),
        .CC_ALUSEQ_done_OutHigh        (done),
        .CC_ALUSEQ_overflow_OutHigh    (overflow),
        .CC_ALUSEQ_valid_OutHigh       (valid),
        .CC_ALUSEQ_value_OutBUS        (value),
        .CC_ALUSEQ_index_OutBUS        (index),
        .CC_ALUSEQ_aluSelection_OutBUS (alu_sel),
        .CC_ALUSEQ_aluDataA_OutBUS     (alu_a),
        .CC_ALUSEQ_aluDataB_OutBUS     (alu_b),
        .CC_ALUSEQ_aluResult_InBUS     (alu_res),
        .CC_ALUSEQ_aluCarry_InLow      (alu_carry_n)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared ALU for the opcodes the sequencer uses.
    always_comb begin
        alu_sum = '0;
        case (alu_sel)
            ALU_OP_BUSA: alu_sum = {1'b0, alu_a};
            ALU_OP_INCA: alu_sum = {1'b0, alu_a} + 9'd1;
            ALU_OP_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            default:     alu_sum = '0;
        endcase
        alu_res     = alu_sum[7:0];
        alu_carry_n = ~alu_sum[8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid strobe.
    always @(posedge clk) begin
        term_t e;
        #1;
        if (busy) busy_seen = 1'b1;
        if (done) done_count++;
        if (valid) begin
            term_count++;
            last_value = value;
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_valid: got index %0d value %0d with no term expected", index, value);
            end else begin
                e = sb.pop_front();
                check("term_value", {24'd0, value}, {24'd0, e.value});
                check("term_index", {27'd0, index}, {27'd0, e.index});
            end
        end
    end

    task automatic push_model(input int n);
        logic [7:0] a, b, f;
        logic [8:0] s;
        a = '0;
        b = '0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) f = 8'd0;
            else if (k == 1) f = 8'd1;
            else begin
                s = {1'b0, a} + {1'b0, b};
                if (s[8] && !WRAP) break;
                f = s[7:0];
            end
            sb.push_back('{value: f, index: k[4:0]});
            a = b;
            b = f;
        end
    endtask

    task automatic run_vector(input vec_t v);
        int lat;
        int exp_lat;
        push_model(v.n);
        term_count = 0;
        busy_seen  = 1'b0;
        exp_lat = (v.exp_ovf && !WRAP) ? v.exp_terms + 1 : v.n;
        @(negedge clk);
        start = 1'b1;
        terms = v.n[4:0];
        @(posedge clk);
        #1;
        check("overflow_cleared_on_start", {31'd0, overflow}, 32'd0);
        lat = done ? 0 : -1;
        @(negedge clk);
        start = 1'b0;
        terms = 5'h1f;
        for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
            start = v.inject && (cyc == 3);
            @(posedge clk);
            #1;
            if (done) lat = cyc;
            else @(negedge clk);
        end
        check("done_latency", lat, exp_lat);
        #2;
        check("term_count", term_count, v.exp_terms);
        check("overflow_at_done", {31'd0, overflow}, {31'd0, v.exp_ovf});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("busy_seen", {31'd0, busy_seen}, {31'd0, (v.n != 0)});
        check("scoreboard_empty", sb.size(), 0);
        if (v.exp_terms > 0) begin
            check("last_value", {24'd0, last_value}, v.exp_last);
            check("index_at_done", {27'd0, index}, v.exp_terms - 1);
        end
        @(negedge clk);
        start = v.inject;
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("no_valid_after_done", {31'd0, valid}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        if (v.inject) begin
            @(posedge clk);
            #1;
            check("start_in_done_ignored", {31'd0, busy | done}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_value"}, {24'd0, value}, 32'd0);
        check({tag, "_index"}, {27'd0, index}, 32'd0);
        check({tag, "_alu_sel"}, {28'd0, alu_sel}, {28'd0, ALU_OP_NOP});
        check({tag, "_alu_ab"}, {16'd0, alu_a, alu_b}, 32'd0);
    endtask

    initial begin
        int  d0;
        bit  got;
        vecs[0] = '{n: 5,  inject: 1'b0, exp_terms: 5,  exp_ovf: 1'b0, exp_last: 3};
        vecs[1] = '{n: 0,  inject: 1'b0, exp_terms: 0,  exp_ovf: 1'b0, exp_last: 0};
        vecs[2] = '{n: 20, inject: 1'b0, exp_terms: WRAP ? 20 : 14, exp_ovf: 1'b1, exp_last: WRAP ? 85 : 233};
        vecs[3] = '{n: 8,  inject: 1'b1, exp_terms: 8,  exp_ovf: 1'b0, exp_last: 13};
        vecs[4] = '{n: 1,  inject: 1'b0, exp_terms: 1,  exp_ovf: 1'b0, exp_last: 0};
        vecs[5] = '{n: 2,  inject: 1'b0, exp_terms: 2,  exp_ovf: 1'b0, exp_last: 1};
        vecs[6] = '{n: 16, inject: 1'b0, exp_terms: WRAP ? 16 : 14, exp_ovf: 1'b1, exp_last: WRAP ? 98 : 233};
        vecs[7] = '{n: 14, inject: 1'b0, exp_terms: 14, exp_ovf: 1'b0, exp_last: 233};
        vecs[8] = '{n: 15, inject: 1'b0, exp_terms: WRAP ? 15 : 14, exp_ovf: 1'b1, exp_last: WRAP ? 121 : 233};
        vecs[9] = '{n: 13, inject: 1'b0, exp_terms: 13, exp_ovf: 1'b0, exp_last: 144};

        rst_n = 1'b0;
        start = 1'b0;
        terms = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vector(vecs[i]);

        // Reset asserted mid-run at index 3 of an N=10 run.
        push_model(10);
        term_count = 0;
        @(negedge clk);
        start = 1'b1;
        terms = 5'd10;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 50 && !got; cyc++) begin
            @(posedge clk);
            #2;
            if (term_count >= 4) got = 1'b1;
        end
        check("reset_wait_index3", {31'd0, got}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        d0 = done_count;
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("done_in_reset", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("no_done_pulse_after_reset", done_count, d0);
        run_vector(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
